// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit: PC owner and ROM read master with a credit-limited prefetch   |
// | FIFO. Optional FETCH_HALT_EN stops fetching on an all-ones word.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_rom_rd,
  output logic [ADDR_W-1:0] o_rom_raddr,
  input  logic [DATA_W-1:0] i_rom_rdata,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_instr_valid,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_instr_pc,
  input  logic              i_instr_ready,
  output logic              o_halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef FETCH_HALT_EN
  typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_t;
`else
  typedef enum logic [0:0] {RUN = 1'b0} state_t;
`endif

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic                inflight;
  logic [ADDR_W-1:0]   inflight_pc;
  logic                kill;
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [ADDR_W-1:0]   pc_q   [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;

  logic                pop;
  logic                push;
  logic                halt_hit;
  logic [CNT_W:0]      occupancy;

  assign o_instr_valid = (count != '0);
  assign o_instr       = data_q[rd_ptr];
  assign o_instr_pc    = pc_q[rd_ptr];

`ifdef FETCH_HALT_EN
  assign o_halted = (state == HALT);
`else
  assign o_halted = 1'b0;
`endif

  always_comb begin
    pop       = o_instr_valid & i_instr_ready;
    // Words already buffered or on their way, net of the one leaving now.
    occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    push      = inflight & ~kill & ~i_redirect & ~rst;
`ifdef FETCH_HALT_EN
    halt_hit  = push & (i_rom_rdata == {DATA_W{1'b1}});
`else
    halt_hit  = 1'b0;
`endif
    o_rom_rd    = 1'b0;
    o_rom_raddr = pc;
    if (rst) begin
      o_rom_raddr = RESET_PC;
    end else if (i_redirect) begin
      o_rom_rd    = 1'b1;
      o_rom_raddr = i_redirect_pc;
    end else if ((state == RUN) && (occupancy < (CNT_W+1)'(DEPTH))) begin
      o_rom_rd    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      kill        <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      inflight <= o_rom_rd;
      if (o_rom_rd) begin
        inflight_pc <= o_rom_raddr;
      end
      if (i_redirect) begin
        // A pop in this cycle is absorbed by the flush itself.
        state  <= RUN;
        pc     <= i_redirect_pc + 1'b1;
        kill   <= 1'b0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (o_rom_rd) begin
          pc <= pc + 1'b1;
        end
        // The read issued alongside a halt word must never reach the FIFO.
        kill <= halt_hit & o_rom_rd;
        if (push) begin
          data_q[wr_ptr] <= i_rom_rdata;
          pc_q[wr_ptr]   <= inflight_pc;
          wr_ptr         <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
`ifdef FETCH_HALT_EN
        if (halt_hit) begin
          state <= HALT;
        end
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end acting as the read-side master of the instruction ROM. It owns the program counter and issues single-cycle read strobes and addresses to the ROM. It captures the 16-bit words returned one cycle later into a small prefetch FIFO and hands them to decode over a valid/ready handshake. Decode or branch logic can redirect it to a new PC.

## Interface
- ADDR_W, 8, ROM word-address width (PC width)
- DATA_W, 16, instruction word width
- RESET_PC, 0, PC loaded on reset
- DEPTH, 2, prefetch FIFO entries (power of two, ≥2)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- o_rom_rd  out  1  ROM read strobe
- o_rom_raddr  out  ADDR_W  ROM read address
- i_rom_rdata  in  DATA_W  ROM data, valid the cycle after o_rom_rd
- i_redirect  in  1  one-cycle redirect request
- i_redirect_pc  in  ADDR_W  redirect target
- o_instr_valid  out  1  FIFO head valid
- o_instr  out  DATA_W  FIFO head instruction
- o_instr_pc  out  ADDR_W  address of o_instr
- i_instr_ready  in  1  decode accepts head when valid & ready
- o_halted  out  1  fetch stopped on halt word (0 without FETCH_HALT_EN)

## Operation
- Registers: pc, inflight flag + inflight_pc, kill flag, FIFO (data + pc per entry, count).
- Fetch state machine: RUN, HALT (HALT reachable only with FETCH_HALT_EN). Reset enters RUN.
- Issue rule (RUN, no rst): o_rom_rd = 1 when count + inflight − pop < DEPTH, with pop = o_instr_valid & i_instr_ready. On issue: o_rom_raddr = pc, pc ← pc + 1, inflight ← 1, inflight_pc ← pc.
- PC increments mod 2^ADDR_W: 0xFF → 0x00 for ADDR_W = 8, with no special handling.
- Response: the cycle after issue, i_rom_rdata and inflight_pc are pushed into the FIFO unless kill is set. If kill is set, the word is dropped and kill clears.
- Simultaneous push and pop: count unchanged. Pop from empty is impossible, since valid = (count ≠ 0). Push never overflows because of the credit rule.
- Redirect has priority over everything except rst.
  - FIFO cleared; o_instr_valid drops the next cycle.
  - Any inflight response is killed.
  - o_rom_rd = 1 with o_rom_raddr = i_redirect_pc in the same cycle, combinationally.
  - pc ← i_redirect_pc + 1; state ← RUN.
- o_rom_rd and o_rom_raddr are combinational from registers and i_redirect. All other outputs come from registers.

## Timing
- While rst is high: o_rom_rd = 0, o_rom_raddr = RESET_PC, o_instr_valid = 0, o_instr = 0, o_instr_pc = 0, o_halted = 0. FIFO, inflight and kill are cleared; pc ← RESET_PC.
- rst asserted mid-operation: identical to power-up. An inflight ROM word arriving the next cycle is ignored.
- First cycle after rst falls (cycle 0): read of RESET_PC. The word enters the FIFO at cycle 1, and o_instr_valid = 1 from cycle 2.
- Issue-to-valid latency is 2 cycles. With i_instr_ready held high, throughput is 1 instruction/cycle.
- i_instr_ready low: at most DEPTH words are buffered/inflight, then o_rom_rd = 0 until a pop.
- Redirect in cycle R: target word is valid at R+2. No stale word is presented at R+1 or later.
- Redirect in the same cycle as a pop: the pop completes, then the flush happens.

## Configuration
- FETCH_HALT_EN defined: when a word equal to all-ones (16'hFFFF) is pushed into the FIFO, state → HALT.
  - o_halted = 1 from the next cycle; o_rom_rd = 0 while halted.
  - A read issued in the halt word's push cycle is killed.
  - The halt word itself is still delivered to decode.
  - Only rst or i_redirect leave HALT.
- FETCH_HALT_EN undefined: 16'hFFFF is an ordinary word, there is no HALT state, and o_halted is constant 0.

## Test plan
- Reset release, ROM loaded with word(n) = 0x1000 + n, ready = 1 → rd at PC 0,1,2…; o_instr = 0x1000, 0x1001… with matching o_instr_pc, first valid 2 cycles after rst falls, one per cycle thereafter.
- Ready low for 10 cycles after first valid → o_rom_rd stops after DEPTH words are held; o_instr holds 0x1000; on release the sequence resumes with no gaps or duplicates.
- i_redirect = 1, i_redirect_pc = 0x40 while FIFO is full → o_rom_raddr = 0x40 that cycle; the next valid instruction has pc 0x40 / 0x1040, two cycles later; no old words appear.
- Run to PC 0xFE, ready = 1 → pcs 0xFE, 0xFF, 0x00, 0x01 delivered in order.
- Pulse rst mid-stream with one read inflight → all outputs at reset values next cycle; the stream restarts at RESET_PC.
- FETCH_HALT_EN, word(5) = 0xFFFF → words 0–5 delivered, o_halted = 1, no further o_rom_rd; redirect to 0 clears o_halted and refetches word 0.
